hub_router_core: RTL and testbench
==================================

// Module: hub_router_core
// PURPOSE
// - Parametrised N-channel message hub: per-channel ingress FIFOs, one round-robin central
//   arbiter, destination-field routing, registered per-channel egress.
// - Next-generation hub core. Replaces the fixed five-port wiring with flat array ports
//   and adds broadcast and drop accounting.
// - Sits between the stage controller on channel 0 and the downstream FPGA links on
//   channels 1..NUM_CHANNELS-1.
// PARAMETERS
// - NUM_CHANNELS   5   number of ports, channel 0 = controller; range 2..16
// - CHANNEL_WIDTH  64  message width in bits
// - DEST_WIDTH     8   destination field, located at msg[CHANNEL_WIDTH-1 -: DEST_WIDTH]
// - FIFO_DEPTH     16  ingress FIFO depth per channel; power of 2, >= 2
// - DROP_CNT_WIDTH 16  width of the dropped-message counter
// PORTS
// - clk            in   1                   single clock
// - reset          in   1                   synchronous, active-high
// - rx_data        in   NUM_CHANNELS*CW     ingress words, channel i at [CW*i +: CW]
// - rx_valid       in   NUM_CHANNELS        ingress valid
// - rx_ready       out  NUM_CHANNELS        ingress ready; high when that FIFO is not full
// - tx_data        out  NUM_CHANNELS*CW     egress words
// - tx_valid       out  NUM_CHANNELS        egress valid
// - tx_ready       in   NUM_CHANNELS        egress ready
// - router_busy    out  1                   any FIFO non-empty, or any tx_valid high
// - dropped_count  out  DROP_CNT_WIDTH      saturating count of discarded messages
// BEHAVIOUR
// - Reset: all outputs 0, FIFOs flushed, arbitration pointer 0, counter 0.
//   - rx_ready rises in the first cycle after reset deasserts.
//   - Reset mid-operation discards every in-flight word; no partial delivery.
// - Handshakes: valid/ready transfer on both sides. tx_valid, once high, holds its
//   tx_data stable until tx_ready.
// - Ingress:
//   - Push on rx_valid && rx_ready.
//   - Push and pop of the same FIFO in one cycle leaves its count unchanged; a push into
//     a full FIFO cannot occur.
// - Egress slot i is free when !tx_valid[i] || tx_ready[i]; free slots are accepted
//   back-to-back.
// - Arbiter:
//   - Each cycle, starting at the channel after the last grant and wrapping mod
//     NUM_CHANNELS, grant the first non-empty head whose target slot(s) are all free.
//   - One grant per cycle. The pointer advances only on a grant.
// - Routing by dest d:
//   - d < NUM_CHANNELS: unicast to slot d; d == source is loopback to the same channel.
//   - d == all-ones: broadcast; see CONFIGURATION.
//   - Any other value: pop and drop, dropped_count += 1, saturating at all-ones.
// - Latency: word pushed in cycle N has its head visible in N+1, is granted in N+1 at
//   the earliest, and tx_valid is high in N+2.
// - Blocked heads stall only their own FIFO; there is no head-of-line effect on other
//   channels.
// CONFIGURATION
// - HUB_BROADCAST_EN defined:
//   - All-ones dest delivers a copy to every channel except the source.
//   - Grant is all-or-nothing: every such slot must be free in the same cycle.
// - Not defined: all-ones dest is treated as invalid, so the message is dropped and
//   counted.
// STRUCTURE
// - Package hub_pkg holds:
//   - localparam BROADCAST_DEST (all-ones)
//   - function dest_of(msg) extracting the destination field
//   - typedef hub_msg_t
// - Sub-module hub_ingress_fifo: circular buffer with count; instanced per channel by a
//   generate loop.
// - Arbiter and egress registers live in the top level.
// TESTING
// - Unicast: ch1 sends dest=0 (data 0xABCD) -> tx_valid[0] two cycles later, exact data,
//   no other tx_valid.
// - Contention: ch1..ch4 each send dest=0 in the same cycle, tx_ready[0]=1 -> delivered
//   in order 1,2,3,4 on consecutive cycles; repeat -> order rotates correctly.
// - Backpressure: tx_ready[2]=0, 20 words sent to dest=2 on ch0 (FIFO_DEPTH=16) ->
//   rx_ready[0] falls after 16+1 accepted, nothing lost; release -> all 17 delivered in
//   order.
// - Broadcast with HUB_BROADCAST_EN: ch0 sends dest=0xFF while tx_ready[3]=0 ->
//   nothing delivered until ch3 frees, then ch1..4 receive it in the same cycle.
// - Drop: dest=0x07 with NUM_CHANNELS=5 (and 0xFF without the macro) -> no tx_valid,
//   dropped_count increments by 1 each; preload near max -> saturates.
// - Reset mid-burst: reset asserted with 3 FIFOs partly full -> next cycle tx_valid=0,
//   router_busy=0, count=0; rx_ready high after release.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared definitions for the hub router core: default message geometry,
// the broadcast destination code and a destination-field helper.
package hub_pkg;

  localparam int HUB_CW = 64;  // default message width
  localparam int HUB_DW = 8;   // default destination field width

  // All-ones destination; truncate to the field width in use.
  localparam logic [31:0] BROADCAST_DEST = 32'hFFFF_FFFF;

  typedef logic [HUB_CW-1:0] hub_msg_t;

  // Destination field sits in the top bits of the message.
  function automatic logic [HUB_DW-1:0] dest_of(input hub_msg_t msg);
    return msg[HUB_CW-1 -: HUB_DW];
  endfunction

endpackage

// File: rtl/hub_ingress_fifo.sv
// Per-channel ingress FIFO: circular buffer with an occupancy count.
// The head word is read straight from storage so the arbiter can see a
// word in the cycle after it was pushed. DEPTH must be a power of two so
// the pointers wrap naturally.
module hub_ingress_fifo
  import hub_pkg::*;
#(
  parameter int WIDTH = HUB_CW,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/hub_router_core.sv
// N-channel message hub: per-channel ingress FIFOs, one round-robin
// arbiter granting at most one head per cycle, destination-field routing
// into registered egress slots, and a saturating dropped-message counter.
// Optional feature macro: HUB_BROADCAST_EN (all-ones destination is
// delivered to every channel except the source; otherwise it is dropped).
module hub_router_core
  import hub_pkg::*;
#(
  parameter int NUM_CHANNELS   = 5,
  parameter int CHANNEL_WIDTH  = HUB_CW,
  parameter int DEST_WIDTH     = HUB_DW,
  parameter int FIFO_DEPTH     = 16,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] rx_data,
  input  logic [NUM_CHANNELS-1:0]               rx_valid,
  output logic [NUM_CHANNELS-1:0]               rx_ready,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] tx_data,
  output logic [NUM_CHANNELS-1:0]               tx_valid,
  input  logic [NUM_CHANNELS-1:0]               tx_ready,
  output logic                                  router_busy,
  output logic [DROP_CNT_WIDTH-1:0]             dropped_count
);

  localparam int CIW = $clog2(NUM_CHANNELS);
  localparam logic [DEST_WIDTH-1:0] BCAST = DEST_WIDTH'(BROADCAST_DEST);

`ifdef HUB_BROADCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  // Per-channel ingress view.
  logic [CHANNEL_WIDTH-1:0] head      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  tmask     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  empty;
  logic [NUM_CHANNELS-1:0]  full;
  logic [NUM_CHANNELS-1:0]  push;
  logic [NUM_CHANNELS-1:0]  pop;
  logic [NUM_CHANNELS-1:0]  slot_free;
  logic [NUM_CHANNELS-1:0]  eligible;

  // Control state.
  logic                     ready_en_q;
  logic [CIW-1:0]           ptr_q;
  logic [CIW-1:0]           ptr_d;
  logic                     grant_vld;
  logic [CIW-1:0]           grant_idx;
  logic [NUM_CHANNELS-1:0]  win_mask;
  logic [CHANNEL_WIDTH-1:0] win_head;

  // Egress and accounting state.
  logic [CHANNEL_WIDTH-1:0]  tx_data_q [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0]  tx_data_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   tx_valid_q;
  logic [NUM_CHANNELS-1:0]   tx_valid_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic [DROP_CNT_WIDTH-1:0] drop_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [DEST_WIDTH-1:0]   dest;
      logic [NUM_CHANNELS-1:0] mask;

      hub_ingress_fifo #(
        .WIDTH (CHANNEL_WIDTH),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset_i (reset),
        .push_i  (push[gi]),
        .pop_i   (pop[gi]),
        .wdata_i (rx_data[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
        .head_o  (head[gi]),
        .empty_o (empty[gi]),
        .full_o  (full[gi])
      );

      // Ready is held low until the first cycle after reset is released.
      assign rx_ready[gi]  = ready_en_q & ~full[gi];
      assign push[gi]      = rx_valid[gi] & rx_ready[gi];
      assign pop[gi]       = grant_vld & (grant_idx == CIW'(gi));
      assign slot_free[gi] = ~tx_valid_q[gi] | tx_ready[gi];
      assign tx_data[gi*CHANNEL_WIDTH +: CHANNEL_WIDTH] = tx_data_q[gi];

      // Decode the head's destination into the set of egress slots it needs;
      // an empty set means the message is dropped when granted.
      always_comb begin
        dest = head[gi][CHANNEL_WIDTH-1 -: DEST_WIDTH];
        mask = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
          if (dest == DEST_WIDTH'(j)) begin
            mask[j] = 1'b1;
          end
        end
        if (BCAST_EN && (mask == '0) && (dest == BCAST)) begin
          mask = ~(NUM_CHANNELS'(1) << gi);
        end
      end

      assign tmask[gi] = mask;
      // A head may go only when every slot it targets is free this cycle.
      assign eligible[gi] = ~empty[gi] & ((mask & ~slot_free) == '0);
    end
  endgenerate

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int           cand;
    logic [CIW-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_CHANNELS) begin
        cand = cand - NUM_CHANNELS;
      end
      cand_idx = CIW'(cand);
      if (!grant_vld && eligible[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
    ptr_d = grant_vld ? grant_idx : ptr_q;
  end

  // Egress slot loading/draining and drop accounting for the winning head.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    drop_d     = drop_q;
    win_mask   = tmask[grant_idx];
    win_head   = head[grant_idx];
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (grant_vld && win_mask[j]) begin
        tx_valid_d[j] = 1'b1;
        tx_data_d[j]  = win_head;
      end else if (tx_ready[j]) begin
        tx_valid_d[j] = 1'b0;
      end
    end
    if (grant_vld && (win_mask == '0) && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Control, egress and counter registers; reset discards all in-flight words.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en_q <= 1'b0;
      ptr_q      <= '0;
      tx_valid_q <= '0;
      drop_q     <= '0;
      for (int j = 0; j < NUM_CHANNELS; j++) begin
        tx_data_q[j] <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      ptr_q      <= ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign router_busy   = (~&empty) | (|tx_valid_q);
  assign dropped_count = drop_q;

endmodule

// File: tb/tb_hub_router_core.sv
// Randomized self-checking bench for hub_router_core against a queue-based
// reference model of the hub. Narrow drop counter so saturation is reachable.
module tb_hub_router_core;
  import hub_pkg::*;

  localparam int NCH   = 5;
  localparam int CW    = 64;
  localparam int DEPTH = 16;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

`ifdef HUB_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH*CW-1:0]   rx_data;
  logic [NCH-1:0]      rx_valid;
  logic [NCH-1:0]      rx_ready;
  logic [NCH*CW-1:0]   tx_data;
  logic [NCH-1:0]      tx_valid;
  logic [NCH-1:0]      tx_ready;
  logic                router_busy;
  logic [DCW-1:0]      dropped_count;

  hub_router_core #(
    .NUM_CHANNELS   (NCH),
    .CHANNEL_WIDTH  (CW),
    .DEST_WIDTH     (8),
    .FIFO_DEPTH     (DEPTH),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .router_busy   (router_busy),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one queue per channel, one expected word per egress slot.
  hub_msg_t mq [NCH][$];
  hub_msg_t m_data  [NCH];
  bit       m_valid [NCH];
  int       m_last  = 0;
  int       m_drops = 0;
  bit       m_en    = 1'b0;
  bit       m_rst   = 1'b0;

  // Slots a message from src must reach; empty set means dropped.
  function automatic logic [NCH-1:0] targets(input hub_msg_t m, input int src);
    int d;
    d = int'(dest_of(m));
    if (d < NCH) return NCH'(1) << d;
    if (BCAST && d == 255) return ~(NCH'(1) << src);
    return '0;
  endfunction

  task automatic model_step();
    bit             acc  [NCH];
    bit             free [NCH];
    int             g;
    int             c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] gt;
    bit             ok;
    m_rst = reset;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        mq[i].delete();
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
      end
      m_last  = 0;
      m_drops = 0;
      m_en    = 1'b0;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      acc[i]  = rx_valid[i] && m_en && (mq[i].size() < DEPTH);
      free[i] = !m_valid[i] || tx_ready[i];
    end
    g  = -1;
    gt = '0;
    for (int k = 1; k <= NCH; k++) begin
      c = (m_last + k) % NCH;
      if (g < 0 && mq[c].size() > 0) begin
        t  = targets(mq[c][0], c);
        ok = 1'b1;
        for (int j = 0; j < NCH; j++) if (t[j] && !free[j]) ok = 1'b0;
        if (ok) begin
          g  = c;
          gt = t;
        end
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (g >= 0 && gt[j]) begin
        m_valid[j] = 1'b1;
        m_data[j]  = mq[g][0];
      end else if (tx_ready[j]) begin
        m_valid[j] = 1'b0;
      end
    end
    if (g >= 0) begin
      if (gt == '0 && m_drops < DMAX) m_drops++;
      void'(mq[g].pop_front());
      m_last = g;
    end
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) mq[i].push_back(rx_data[i*CW +: CW]);
    end
    m_en = 1'b1;
  endtask

  task automatic check_outputs();
    bit busy;
    busy = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      check_eq($sformatf("tx_valid[%0d]", j), 64'(tx_valid[j]), 64'(m_valid[j]));
      if (m_valid[j] || m_rst)
        check_eq($sformatf("tx_data[%0d]", j), tx_data[j*CW +: CW], m_data[j]);
      check_eq($sformatf("rx_ready[%0d]", j), 64'(rx_ready[j]),
               64'(m_en && (mq[j].size() < DEPTH)));
      if (mq[j].size() > 0 || m_valid[j]) busy = 1'b1;
    end
    check_eq("router_busy", 64'(router_busy), 64'(busy));
    check_eq("dropped_count", 64'(dropped_count), 64'(m_drops));
  endtask

  // Inputs are set at the falling edge; the DUT samples them at the next rise.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  function automatic hub_msg_t mk(input int dest);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {8'(dest), r[55:0]};
  endfunction

  function automatic int rand_dest();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return r % NCH;
    if (r == 7) return 7;
    if (r == 8) return 255;
    return $urandom_range(NCH, 254);
  endfunction

  task automatic set_rx(input int i, input hub_msg_t m);
    rx_data[i*CW +: CW] = m;
    rx_valid[i] = 1'b1;
  endtask

  task automatic random_phase(input int n, input int load, input int rbias);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 99) < load) set_rx(i, mk(rand_dest()));
        else rx_valid[i] = 1'b0;
        tx_ready[i] = ($urandom_range(0, 99) < rbias);
      end
      cycle();
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = '0;
    rx_data  = '0;
    tx_ready = '1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Single unicast, channel 1 to channel 0.
    set_rx(1, {8'h00, 56'hABCD});
    cycle();
    rx_valid = '0;
    repeat (4) cycle();

    // Four-way contention for slot 0, twice so the pointer rotation is exercised.
    repeat (2) begin
      for (int i = 1; i < NCH; i++) set_rx(i, mk(0));
      cycle();
      rx_valid = '0;
      repeat (6) cycle();
    end

    // Backpressure on slot 2 while channel 0 offers 20 words.
    tx_ready    = '1;
    tx_ready[2] = 1'b0;
    for (int n = 0; n < 20; n++) begin
      set_rx(0, mk(2));
      cycle();
    end
    rx_valid    = '0;
    tx_ready[2] = 1'b1;
    repeat (22) cycle();

    // Broadcast while slot 3 is occupied and stalled.
    tx_ready    = '1;
    tx_ready[3] = 1'b0;
    set_rx(1, mk(3));
    cycle();
    rx_valid = '0;
    set_rx(0, mk(255));
    cycle();
    rx_valid = '0;
    repeat (5) cycle();
    tx_ready[3] = 1'b1;
    repeat (5) cycle();

    // Invalid destinations, enough to saturate the counter.
    for (int n = 0; n < 20; n++) begin
      set_rx(n % NCH, mk(7));
      cycle();
    end
    rx_valid = '0;
    repeat (5) cycle();

    // Reset in the middle of a stalled burst.
    tx_ready = '0;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 3; i++) set_rx(i, mk(rand_dest()));
      cycle();
    end
    reset = 1'b1;
    cycle();
    reset    = 1'b0;
    rx_valid = '0;
    tx_ready = '1;
    cycle();
    cycle();

    // Randomized traffic under varying load and egress pressure.
    random_phase(1000, 30, 90);
    random_phase(1000, 80, 40);
    random_phase(1000, 60, 10);
    rx_valid = '0;
    tx_ready = '1;
    repeat (100) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
